// File: rtl/rst_sync.sv
// Reset conditioner: turns the synchronous active-high RST into a registered,
// glitch-free, active-low domain reset SYNC_RST. Release follows a run of
// no_stg stage edges plus RST_STRETCH hold edges, all with RST low.
module rst_sync #(
  parameter int no_stg      = 2,
  parameter int RST_STRETCH = 0
) (
  input  logic CLK,
  input  logic RST,
  output logic SYNC_RST
);

  // Reject illegal parameterisations at elaboration time
  generate
    if (no_stg < 2 || no_stg > 8) begin : g_bad_stg
      $error("rst_sync: no_stg must be in 2..8");
    end
    if (RST_STRETCH < 0 || RST_STRETCH > 255) begin : g_bad_stretch
      $error("rst_sync: RST_STRETCH must be in 0..255");
    end
  endgenerate

  logic [no_stg-1:0] stg;
  logic [no_stg-1:0] stg_n;
  logic [7:0]        hold_n;

  // Next value of the stage chain: shift a one in from the bottom
  assign stg_n = {stg[no_stg-2:0], 1'b1};

  generate
    if (RST_STRETCH > 0) begin : g_hold
      logic [7:0] hold_cnt;

      // Hold counter counts down once the chain has filled
      always_comb begin
        hold_n = hold_cnt;
        if (stg[no_stg-1] && (hold_cnt != '0)) begin
          hold_n = hold_cnt - 8'd1;
        end
      end

      // Hold counter register, reloaded by every sampled RST
      always_ff @(posedge CLK) begin
        if (RST) begin
          hold_cnt <= 8'(RST_STRETCH);
        end else begin
          hold_cnt <= hold_n;
        end
      end
    end else begin : g_no_hold
      assign hold_n = '0;
    end
  endgenerate

  // Stage chain and output flop; SYNC_RST is computed from the next-state
  // values so it rises on the no_stg-th (plus stretch) edge with RST low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stg      <= '0;
      SYNC_RST <= 1'b0;
    end else begin
      stg      <= stg_n;
      SYNC_RST <= stg_n[no_stg-1] && (hold_n == '0);
    end
  end

endmodule

// File: tb/tb_rst_sync.sv
module tb_rst_sync;

  logic CLK;
  logic RST;
  logic sync_a;  // no_stg=2, RST_STRETCH=0
  logic sync_b;  // no_stg=4, RST_STRETCH=3
  logic sync_c;  // no_stg=8, RST_STRETCH=0

  int total;
  int bad;

  // Reference: count of consecutive edges sampling RST low since the last
  // edge sampling RST high; an instance is released once the count reaches
  // no_stg + RST_STRETCH.
  int zeros;
  bit seen_rst;
  localparam int THR_A = 2;
  localparam int THR_B = 7;
  localparam int THR_C = 8;

  rst_sync #(.no_stg(2), .RST_STRETCH(0)) dut_a (.CLK(CLK), .RST(RST), .SYNC_RST(sync_a));
  rst_sync #(.no_stg(4), .RST_STRETCH(3)) dut_b (.CLK(CLK), .RST(RST), .SYNC_RST(sync_b));
  rst_sync #(.no_stg(8), .RST_STRETCH(0)) dut_c (.CLK(CLK), .RST(RST), .SYNC_RST(sync_c));

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) begin
      zeros    <= 0;
      seen_rst <= 1'b1;
    end else if (zeros < 100000) begin
      zeros <= zeros + 1;
    end
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_a"}, sync_a, logic'(zeros >= THR_A));
    check({tag, "_b"}, sync_b, logic'(zeros >= THR_B));
    check({tag, "_c"}, sync_c, logic'(zeros >= THR_C));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    zeros    = 0;
    seen_rst = 1'b0;

    // Power-up with RST high
    RST = 1'b1;
    #20;                          // t=20
    check("pwrup_a", sync_a, 1'b0);
    check("pwrup_b", sync_b, 1'b0);
    check("pwrup_c", sync_c, 1'b0);
    #10;                          // t=30
    check("pwrup30", sync_a, 1'b0);

    // Release: RST low at 35, edge 50 first low sample, edge 70 release
    #5  RST = 1'b0;               // t=35
    #25 check("rel_60", sync_a, 1'b0);   // t=60
    #20 check("rel_80", sync_a, 1'b1);   // t=80
    check_model("rel80");

    // Synchronous assert: RST high 85..95, sampled at edge 90
    #5  RST = 1'b1;               // t=85
    #10 RST = 1'b0;               // t=95
    // Glitch 97..101 with no edge inside
    #2  RST = 1'b1;               // t=97
    #3  check("asrt_100", sync_a, 1'b0); // t=100
    #1  RST = 1'b0;               // t=101
    #19 check("rel_120", sync_a, 1'b0);  // t=120
    #20 check("rel_140", sync_a, 1'b1);  // t=140
    check_model("rel140");

    // Glitch rejection while released: pulse between edges 150 and 170
    #13 RST = 1'b1;               // t=153
    #2  RST = 1'b0;               // t=155
    #5  check("glitch_160", sync_a, 1'b1);
    #20 check("glitch_180", sync_a, 1'b1);
    check_model("glitch");

    // Mid-release restart: one low edge, then a high edge
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK) RST = 1'b1;    // chain has one stage set when RST returns
    @(negedge CLK);
    check("restart_hold", sync_a, 1'b0);
    RST = 1'b0;
    @(negedge CLK) check("restart_e1", sync_a, 1'b0);
    @(negedge CLK) check("restart_e2", sync_a, 1'b1);

    // Stretch and long-chain release counts
    RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge CLK);
      check($sformatf("cnt_b_e%0d", e), sync_b, logic'(e >= 7));
      check($sformatf("cnt_c_e%0d", e), sync_c, logic'(e >= 8));
    end

    // Randomised RST with occasional short and long pulses
    for (int n = 0; n < 600; n++) begin
      @(negedge CLK);
      if ($urandom_range(0, 11) == 0) RST = 1'b1;
      else if ($urandom_range(0, 3) == 0) RST = 1'b0;
      else if (RST && $urandom_range(0, 1) == 0) RST = 1'b0;
      #3;
      if (seen_rst) check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
